// File: rtl/uart_receiver_if.sv
// Receive-byte handshake bundle between the UART receiver and its consumer.
// The receiver drives the byte and its valid flag, and the consumer answers
// with ready. A byte moves across when valid and ready are both 1 on a
// rising clock edge.
interface uart_receiver_if;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;

  modport master (
    output DataOut,
    output DataOutValid,
    input  DataOutReady
  );

  modport slave (
    input  DataOut,
    input  DataOutValid,
    output DataOutReady
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receive path.
// SIn goes through a two-flop synchronizer. A five-state FSM then samples the
// start bit at mid-bit, takes the eight data bits LSB first, and checks the
// stop bit. A finished frame is handed to a single-entry output buffer one
// cycle after the stop-bit sample. That hand-off cycle is also where a
// framing error shows up as a one-cycle pulse.
module uart_receiver #(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            SIn,
  uart_receiver_if.master rx,
  output logic            FramingError,
  output logic            Overrun
);

  localparam int SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int SampleTime     = SymbolEdgeTime / 2;
  localparam int CNT_W          = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SampleTime - 1);
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SymbolEdgeTime - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchronizer flops, both idling high like the line itself
  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             w_rx_s;

  // Frame FSM state
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             w_frame_ok;
  logic             w_frame_bad;

  // Stop-bit verdict, delayed one cycle before it reaches the buffer
  logic             r_vld_p1;
  logic             r_bad_p1;

  // Output buffer and status flags
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ovr;
  logic             r_ferr;
  logic             w_pop;

  assign w_rx_s           = r_sync_p1;
  assign w_pop            = r_valid & rx.DataOutReady;
  assign rx.DataOut       = r_data;
  assign rx.DataOutValid  = r_valid;
  assign FramingError     = r_ferr;
  assign Overrun          = r_ovr;

  // --- stage p0/p1: bring the asynchronous serial line into the clock domain
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
    end else begin
      r_sync_p0 <= SIn;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Frame FSM registers: state, bit-time counter, bit index, shift register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Frame FSM next state: mid-bit sampling of start, data and stop bits
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_frame_ok  = 1'b0;
    w_frame_bad = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end

      S_START: begin
        // Half a bit in, we are at the middle of the start bit. A line that
        // is already high again is treated as noise.
        if (r_cnt == SAMPLE_LAST) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          if (w_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_DATA: begin
        // From here on, every full bit time lands at the middle of the next bit
        if (r_cnt == SYMBOL_LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rx_s;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_STOP: begin
        // Go back to IDLE right at mid-stop so the next start bit is never missed
        if (r_cnt == SYMBOL_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_frame_ok  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_bad = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_BREAK: begin
        // A line held low must go back to idle-high before a new frame can start
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // --- stage p1: register the stop-bit verdict before the buffer acts on it
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_vld_p1 <= 1'b0;
      r_bad_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_frame_ok;
      r_bad_p1 <= w_frame_bad;
    end
  end

  // Single-entry output buffer with sticky overrun and one-cycle framing pulse.
  // r_shift is still intact here because the FSM cannot be back in DATA yet.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= r_bad_p1;

      if (r_vld_p1 && (!r_valid || w_pop)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end

      if (r_vld_p1 && r_valid && !w_pop) begin
        r_ovr <= 1'b1;
      end else if (w_pop) begin
        r_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive half of the board UART: deserializes 8N1 frames arriving on the FPGA serial input pin and presents each byte on a ready/valid interface. Its consumer is the memory-mapped IO interface: it polls `DataOutValid` through the UART control register and pops the byte with `DataOutReady` when the CPU reads the receive-data address. Only the receive path is covered here. The transmit serializer is a separate block.

## Interface
- `ClockFreq`, default 50_000_000, system clock frequency in Hz.
- `BaudRate`, default 115_200, line rate in bits/s.
- Derived `SymbolEdgeTime` = ClockFreq / BaudRate, integer division; 434 at defaults.
- Derived `SampleTime` = SymbolEdgeTime / 2, integer division; 217 at defaults.
- `Clock`  in  1  system clock; everything is on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `SIn`  in  1  serial line; idles high; asynchronous to `Clock`.
- `DataOut`  out  8  received byte, held stable while `DataOutValid` is 1.
- `DataOutValid`  out  1  byte available.
- `DataOutReady`  in  1  consumer accepts the byte; a transfer occurs when Valid and Ready are both 1.
- `FramingError`  out  1  one-cycle pulse when the stop bit samples as 0.
- `Overrun`  out  1  sticky flag: a frame completed while the buffer was still full.

## Operation
- `SIn` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- The FSM has states IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** if `rx_s` is 0, go to START and clear the counter.
  - **START:** the counter runs 0..SampleTime-1. At SampleTime-1, sample `rx_s`. If it is 1, this is a glitch: return to IDLE. If it is 0, go to DATA with the counter and bit index cleared.
  - **DATA:** the counter runs 0..SymbolEdgeTime-1. At SymbolEdgeTime-1, shift `rx_s` into bit[index], LSB first, and clear the counter. After index 7 is captured, go to STOP.
  - **STOP:** at SymbolEdgeTime-1, sample `rx_s`.
    - If it is 1 and the buffer is empty, or is being drained this cycle, load `DataOut` from the shift register, set `DataOutValid`, and go to IDLE.
    - If it is 1 and the buffer is full with no drain this cycle, drop the new byte, keep the old byte, set `Overrun`, and go to IDLE.
    - If it is 0, pulse `FramingError`, discard the byte, and go to BREAK.
  - **BREAK:** wait for `rx_s` to be 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- **Buffer:** one entry. A handshake (Valid & Ready) clears `DataOutValid` on the next edge. A handshake and a new load in the same cycle leave `DataOutValid` at 1 with the new data.
- **Overrun:** stays set until the next handshake, then clears.
- **Counters:** the counter width is clog2(SymbolEdgeTime) and it never wraps mid-bit. The bit index is 3 bits.
- **Reset:** asserting `Reset` mid-frame aborts the frame. The FSM returns to IDLE, and the shift register, counter and index clear.

## Timing
- **Reset values:** `DataOut` = 8'h00, `DataOutValid` = 0, `FramingError` = 0, `Overrun` = 0, FSM = IDLE.
- **Latency:** let edge k be the first rising edge where `SIn` is sampled low. Data is sampled at mid-bit:
  - `DataOutValid` rises at edge k + 2 + SampleTime + 9*SymbolEdgeTime + 1.
  - `FramingError` pulses high for exactly one cycle, in the cycle where `DataOutValid` would otherwise have risen.
- The stop bit is sampled at its midpoint and the FSM returns to IDLE immediately. A start bit that begins at the nominal stop-bit end is therefore detected with no dead time, so back-to-back frames are supported.
- `DataOut` changes only on the cycle `DataOutValid` goes 0→1, or when valid stays 1 under a simultaneous pop and load.
- `DataOutReady` while `DataOutValid` = 0 has no effect.
- Maximum throughput is one byte per 10*SymbolEdgeTime cycles.

## Test plan
All scenarios use ClockFreq=1000 and BaudRate=100, so SymbolEdgeTime=10 and SampleTime=5.
- **Single byte:** drive frame 8'hAA; hold Ready=0. Required: Valid rises exactly 98 cycles after the start edge, `DataOut`=8'hAA, and it stays stable until Ready=1; Valid falls one cycle after the handshake.
- **Glitch:** pulse `SIn` low for 3 cycles. Required: FSM returns to IDLE, no Valid, no FramingError.
- **Framing error:** drive 8'h55 with stop bit 0, then hold the line low for 30 cycles. Required:
  - exactly one FramingError pulse;
  - Valid stays 0;
  - no new frame until the line returns high, after which an 8'h0F frame is received correctly.
- **Overrun:** send 8'h11 then 8'h22 back to back with Ready=0. Required: `DataOut`=8'h11 and `Overrun`=1. After a pop, `Overrun`=0 and Valid=0.
- **Same-cycle pop and load:** assert Ready in exactly the cycle the second byte (8'h22) completes. Required: Valid stays 1, `DataOut`=8'h22, and `Overrun` stays 0.
- **Reset mid-frame:** assert Reset during DATA bit 4 of 8'hF0, then send 8'h3C. Required: all outputs at reset values immediately, and only 8'h3C is delivered.
